// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot / auto-reload modes
// and a maskable interrupt; responder for bridge store transactions.
module timer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       dev_addr,
  input  logic             dev_we,
  input  logic [3:0]       dev_be,
  input  logic [WIDTH-1:0] dev_wd,
  output logic [WIDTH-1:0] dev_rd,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  logic             wr_ctrl, wr_preset;
  logic [31:0]      be_bytes;
  logic [WIDTH-1:0] be_mask;

  assign wr_ctrl   = dev_we && (dev_addr == 2'd0);
  assign wr_preset = dev_we && (dev_addr == 2'd1);
  assign be_bytes  = {{8{dev_be[3]}}, {8{dev_be[2]}}, {8{dev_be[1]}}, {8{dev_be[0]}}};
  assign be_mask   = WIDTH'(be_bytes);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      IDLE: if (ctrl_q[0]) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (ctrl_q[2:1] == 2'b01) begin
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // CPU writes are applied last so they override the FSM's own EN clear.
    if (wr_ctrl) begin
      if (dev_be[0]) ctrl_d = dev_wd[3:0];
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = (preset_q & ~be_mask) | (dev_wd & be_mask);
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    dev_rd = '0;
    case (dev_addr)
      2'd0:    dev_rd = WIDTH'(ctrl_q);
      2'd1:    dev_rd = preset_q;
      2'd2:    dev_rd = count_q;
      default: dev_rd = '0;
    endcase
  end

  assign irq = ctrl_q[3] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expected values are queued when stimulus
// is driven and popped against DUT outputs with immediate assertions.
module tb_timer_counter;

  logic        clk;
  logic        rstn;
  logic [1:0]  dev_addr;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_wd;
  logic [31:0] dev_rd;
  logic        irq;

  timer_counter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .dev_addr (dev_addr),
    .dev_we   (dev_we),
    .dev_be   (dev_be),
    .dev_wd   (dev_wd),
    .dev_rd   (dev_rd),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=0x%0h expected=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] v);
    push(tag, v);
    dev_addr = a;
    #1;
    pop_chk(dev_rd);
  endtask

  task automatic chk_irq(input string tag, input logic v);
    push(tag, {31'b0, v});
    pop_chk({31'b0, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    dev_addr = a;
    dev_be   = be;
    dev_wd   = d;
    dev_we   = 1'b1;
    tick();
    dev_we   = 1'b0;
    dev_be   = '0;
    dev_wd   = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    dev_addr = '0;
    dev_we   = 1'b0;
    dev_be   = '0;
    dev_wd   = '0;
    tick();
    tick();

    // Reset defaults
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_ctrl", 2'd0, 32'h0);
    chk_rd("rst_preset", 2'd1, 32'h0);
    chk_rd("rst_count", 2'd2, 32'h0);
    rstn = 1'b1;
    tick();
    chk_rd("rst_rsv", 2'd3, 32'h0);

    // PRESET=0 with MODE=10 (one-shot behaviour): INT at E3, EN cleared after
    wr(2'd0, 4'h1, 32'hD);
    tick();
    tick();
    chk_rd("p0_count", 2'd2, 32'h0);
    chk_irq("p0_irq_e2", 1'b0);
    tick();
    chk_irq("p0_irq_e3", 1'b1);
    tick();
    chk_rd("p0_ctrl", 2'd0, 32'hC);
    do_reset();

    // One-shot, PRESET=5
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'h1, 32'h9);
    tick();
    tick();
    for (int i = 0; i <= 5; i++) begin
      chk_rd("os_count", 2'd2, 32'(5 - i));
      chk_irq("os_irq", i == 5);
      if (i < 5) tick();
    end
    tick();
    tick();
    chk_rd("os_ctrl", 2'd0, 32'h8);
    chk_irq("os_irq_hold", 1'b1);
    chk_rd("os_count_hold", 2'd2, 32'h0);
    wr(2'd0, 4'h1, 32'h0);
    chk_irq("os_irq_clr", 1'b0);
    do_reset();

    // Auto-reload, PRESET=3 then 6 mid-count
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'h1, 32'hB);
    for (int c = 1; c <= 22; c++) begin
      tick();
      chk_irq("ar_irq", (c >= 5) && ((c - 5) % 5 == 0));
    end
    wr(2'd1, 4'hF, 32'd6);
    chk_irq("ar_irq_e23", 1'b0);
    for (int c = 24; c <= 42; c++) begin
      tick();
      chk_irq("ar_irq6", (c == 25) || (c == 33) || (c == 41));
      if (c == 27) chk_rd("ar_reload6", 2'd2, 32'd6);
    end
    do_reset();

    // Collision: CTRL write on the edge leaving one-shot INT
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'h1, 32'h9);
    tick();
    tick();
    tick();
    tick();
    chk_irq("col_irq_int", 1'b1);
    wr(2'd0, 4'h1, 32'h9);
    chk_rd("col_ctrl", 2'd0, 32'h9);
    chk_irq("col_irq_clr", 1'b0);
    tick();
    tick();
    chk_rd("col_count", 2'd2, 32'd2);
    tick();
    tick();
    chk_irq("col_irq2", 1'b1);

    // Asynchronous reset while irq is high
    #1;
    rstn = 1'b0;
    #1;
    chk_irq("arst_irq", 1'b0);
    chk_rd("arst_count", 2'd2, 32'h0);
    tick();
    rstn = 1'b1;
    tick();
    chk_rd("arst_ctrl", 2'd0, 32'h0);
    chk_rd("arst_preset", 2'd1, 32'h0);
    tick();
    tick();
    tick();
    chk_rd("arst_hold", 2'd2, 32'h0);

    // Disable mid-count, read-only COUNT, reserved offset, re-enable
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'h1, 32'h1);
    for (int i = 0; i < 6; i++) tick();
    chk_rd("dis_count6", 2'd2, 32'd6);
    wr(2'd0, 4'h1, 32'h0);
    chk_rd("dis_count", 2'd2, 32'd5);
    tick();
    tick();
    tick();
    chk_rd("dis_hold", 2'd2, 32'd5);
    chk_irq("dis_irq", 1'b0);
    wr(2'd2, 4'hF, 32'hABCD);
    chk_rd("cnt_ro", 2'd2, 32'd5);
    wr(2'd3, 4'hF, 32'h1234);
    chk_rd("rsv_ro", 2'd3, 32'h0);
    wr(2'd0, 4'h1, 32'h1);
    tick();
    tick();
    chk_rd("dis_reload", 2'd2, 32'd10);

    // Byte enables
    wr(2'd1, 4'hF, 32'hFFFF_FFFF);
    wr(2'd1, 4'b0010, 32'h0000_1200);
    chk_rd("be_preset", 2'd1, 32'hFFFF_12FF);
    wr(2'd0, 4'b1110, 32'hF);
    chk_rd("ctrl_be", 2'd0, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter (timer) sitting on the device side of the processor I/O bridge. It is the responder for bridge store transactions: it decodes word address, write enable, byte enables and write data, and it returns read data. It supports one-shot and auto-reload modes and drives a maskable interrupt toward the CPU.

## Interface
- `WIDTH`, default 32: width of the PRESET and COUNT registers, and of the data bus.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `dev_addr` input 2: word offset within the device, taken from bridge word address bits [3:2].
- `dev_we` input 1: write strobe for one cycle; the bridge qualifies it with device select.
- `dev_be` input 4: byte enables for the write, aligned to the word lanes.
- `dev_wd` input WIDTH: write data, already shifted to its byte lane.
- `dev_rd` output WIDTH: combinational read data for `dev_addr`.
- `irq` output 1: interrupt request, equal to `IM & irq_flag`.

## Operation
Register map:
- Offset 0 is CTRL, read/write.
  - bit0 `EN`.
  - bits[2:1] `MODE`: 00 is one-shot, 01 is auto-reload, 1x behaves as 00.
  - bit3 `IM`.
  - bits[31:4] read as 0.
- Offset 1 is PRESET, read/write.
- Offset 2 is COUNT, read-only; writes are ignored.
- Offset 3 is reserved: reads return 0, writes are ignored.

Write rules:
- Byte lane k is updated only when `dev_be[k]=1` and `dev_we=1`.
- A CTRL write uses byte 0 only.
- A write to CTRL or PRESET clears `irq_flag`.

FSM states are IDLE, LOAD, CNT and INT.
- **IDLE:** if `EN`=1, go to LOAD. Otherwise stay, and COUNT holds.
- **LOAD:** COUNT <= PRESET, then go to CNT.
- **CNT:**
  - If `EN`=0, go to IDLE; COUNT holds its value.
  - Else if COUNT > 1, COUNT <= COUNT-1.
  - Else (COUNT is 1 or 0): COUNT <= 0, `irq_flag` <= 1, go to INT.
- **INT, MODE=00:** `EN` <= 0, go to IDLE. `irq_flag` stays 1 until a CTRL or PRESET write.
- **INT, MODE=01:** `irq_flag` <= 0, go directly to LOAD. `EN` remains 1.

Arithmetic and priority rules:
- The decrement is unsigned, with no wrap below 0.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- If a CPU CTRL write and the INT-state `EN` clear fall on the same edge, the CPU write wins.
- A CTRL write with `EN`=0 during LOAD: COUNT is still loaded, then the FSM goes to IDLE on the next CNT cycle.

Reset values:
- CTRL=0, PRESET=0, COUNT=0.
- State is IDLE.
- `irq_flag`=0, so `irq`=0.
- `dev_rd` reflects these zero registers.

## Timing
- Writes take effect at the rising edge where `dev_we`=1.
- `dev_rd` is combinational, with 0-cycle latency from `dev_addr` and the register state.
- For PRESET=N≥1 and an `EN` write at edge E0:
  - LOAD state is entered at E1.
  - COUNT=N and CNT state at E2.
  - COUNT reaches 0 and INT is entered at E(2+N).
  - `irq` rises after E(2+N) when `IM`=1.
- PRESET=0 gives INT at E3.
- Auto-reload period is N+2 cycles from INT to INT. `irq` is high for exactly 1 cycle per period.
- Asynchronous reset mid-count clears all state immediately; counting resumes only after `EN` is rewritten.
- `IM` gates `irq` combinationally. `irq_flag` is set regardless of `IM`.

## Test plan
- **Reset defaults:** assert `rstn`=0 mid-count → `irq`=0 immediately; reads at offsets 0, 1, 2 all return 0 after release.
- **One-shot:**
  - Stimulus: PRESET=5, then CTRL=0x9.
  - COUNT reads 5, 4, 3, 2, 1, 0 on successive cycles.
  - `irq`=1 from the cycle after E7 and stays high; CTRL reads 0x8.
  - Writing CTRL=0x0 drops `irq` the next cycle.
- **Auto-reload:**
  - Stimulus: PRESET=3, CTRL=0xB.
  - `irq` gives 1-cycle pulses every 5 cycles for at least 4 periods.
  - A PRESET write to 6 mid-count takes effect only after the next reload, giving an 8-cycle period.
- **Byte enables:**
  - PRESET=0xFFFFFFFF, then a write of 0x00001200 with `dev_be`=0010 → PRESET reads 0xFFFF12FF.
  - A write to offset 2 leaves COUNT unchanged.
- **Disable mid-count:**
  - PRESET=10, `EN`=1; clear `EN` when COUNT=6 → COUNT holds at 5 or 6 per FSM rule and `irq` stays 0.
  - Re-enable → COUNT reloads to 10.
- **Collision:** CTRL write of 0x9 on the same edge as one-shot INT → `EN` stays 1 and a new count starts; `irq_flag` is cleared.
